// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester access arbiter for a single-port data RAM. The CPU data port
// and an optional debug port compete for the RAM; each granted access
// takes one ISSUE cycle, where the RAM strobes are driven, followed by one
// RESP cycle, where the read data is returned together with a one-cycle
// completion pulse.
//
// Optional feature macro: MEM_ARB_DBG_EN
//   defined   : debug port and round-robin arbitration are built.
//   undefined : dbg_* inputs are ignored, dbg_ack/dbg_rdata are tied low and
//               only the CPU path exists, with identical CPU timing.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   cpu_req    CPU access request
//   cpu_we     CPU write enable (1 = write, 0 = read)
//   cpu_addr   CPU word address
//   cpu_wdata  CPU write data
//   cpu_ready  one-cycle CPU completion pulse
//   cpu_rdata  CPU read data, valid while cpu_ready = 1, otherwise 0
//   dbg_req    debug access request
//   dbg_we     debug write enable
//   dbg_addr   debug word address
//   dbg_wdata  debug write data
//   dbg_ack    one-cycle debug completion pulse
//   dbg_rdata  debug read data, valid while dbg_ack = 1, otherwise 0
//   mem_en     registered RAM enable (high for exactly the ISSUE cycle)
//   mem_we     registered RAM write strobe
//   mem_addr   registered RAM address
//   mem_wdata  registered RAM write data
//   mem_rdata  RAM read data, valid one cycle after a read enable
//   arb_busy   high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE_CPU = 3'd1,
`ifdef MEM_ARB_DBG_EN
        RESP_CPU  = 3'd2,
        ISSUE_DBG = 3'd3,
        RESP_DBG  = 3'd4
`else
        RESP_CPU  = 3'd2
`endif
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   arb_open_s;
    logic   grant_cpu_s;

`ifdef MEM_ARB_DBG_EN
    // prio_r points at the requester that was NOT granted last.
    localparam logic PRIO_CPU = 1'b0;
    localparam logic PRIO_DBG = 1'b1;

    logic prio_r;
    logic grant_dbg_s;
`else
    // Debug inputs have no function in this build; fold them into one
    // deliberately unused net so they are visibly accounted for.
    logic dbg_unused_s;
    assign dbg_unused_s = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata};
`endif

    // Arbitration is open in IDLE and in every RESP state so that a new
    // access can be granted back-to-back with the previous response.
    always_comb begin
        arb_open_s = 1'b0;
        case (state_r)
            IDLE:     arb_open_s = 1'b1;
            RESP_CPU: arb_open_s = 1'b1;
`ifdef MEM_ARB_DBG_EN
            RESP_DBG: arb_open_s = 1'b1;
`endif
            default:  arb_open_s = 1'b0;
        endcase
    end

`ifdef MEM_ARB_DBG_EN
    // Round-robin grant: the priority pointer only matters on a tie; a lone
    // requester always wins.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_dbg_s = 1'b0;
        if (arb_open_s) begin
            if (cpu_req && dbg_req) begin
                if (prio_r == PRIO_DBG) begin
                    grant_dbg_s = 1'b1;
                end else begin
                    grant_cpu_s = 1'b1;
                end
            end else if (cpu_req) begin
                grant_cpu_s = 1'b1;
            end else if (dbg_req) begin
                grant_dbg_s = 1'b1;
            end else begin
                grant_cpu_s = 1'b0;
            end
        end else begin
            grant_cpu_s = 1'b0;
        end
    end
`else
    // Only the CPU can be granted in this build.
    always_comb begin
        grant_cpu_s = 1'b0;
        if (arb_open_s) begin
            grant_cpu_s = cpu_req;
        end else begin
            grant_cpu_s = 1'b0;
        end
    end
`endif

    // Next-state logic: ISSUE always advances to its RESP state; every
    // arbitration state goes to the winner's ISSUE state or back to IDLE.
    // Grants are forced low outside arbitration states, so an illegal
    // encoding falls through to IDLE.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            ISSUE_CPU: state_nxt_s = RESP_CPU;
`ifdef MEM_ARB_DBG_EN
            ISSUE_DBG: state_nxt_s = RESP_DBG;
`endif
            default: begin
                if (grant_cpu_s) begin
                    state_nxt_s = ISSUE_CPU;
`ifdef MEM_ARB_DBG_EN
                end else if (grant_dbg_s) begin
                    state_nxt_s = ISSUE_DBG;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
        endcase
    end

    // State register plus all registered outputs. RAM strobes are loaded on
    // the grant edge so requester fields are don't-care from then on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            cpu_ready <= 1'b0;
            arb_busy  <= 1'b0;
`ifdef MEM_ARB_DBG_EN
            prio_r    <= PRIO_CPU;
            dbg_ack   <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            arb_busy  <= (state_nxt_s != IDLE);
            cpu_ready <= (state_nxt_s == RESP_CPU);
`ifdef MEM_ARB_DBG_EN
            dbg_ack   <= (state_nxt_s == RESP_DBG);
            mem_en    <= grant_cpu_s | grant_dbg_s;
`else
            mem_en    <= grant_cpu_s;
`endif
            if (grant_cpu_s) begin
                mem_we    <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
`ifdef MEM_ARB_DBG_EN
                prio_r    <= PRIO_DBG;
            end else if (grant_dbg_s) begin
                mem_we    <= dbg_we;
                mem_addr  <= dbg_addr;
                mem_wdata <= dbg_wdata;
                prio_r    <= PRIO_CPU;
`endif
            end else begin
                // Write strobe only lives for the ISSUE cycle; address and
                // data simply hold.
                mem_we    <= 1'b0;
            end
        end
    end

    // RAM data arrives during the RESP cycle itself, so the read data path
    // is a gated pass-through qualified by the registered pulse.
    assign cpu_rdata = cpu_ready ? mem_rdata : {DATA_W{1'b0}};

`ifdef MEM_ARB_DBG_EN
    assign dbg_rdata = dbg_ack ? mem_rdata : {DATA_W{1'b0}};
`else
    assign dbg_ack   = 1'b0;
    assign dbg_rdata = {DATA_W{1'b0}};
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-002 Parameter ADDR_W, 10, data memory word-address width.
REQ-003 Parameter DATA_W, 16, data word width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 cpu_req  input  1  CPU data-memory access request (from control unit decode).
REQ-007 cpu_we  input  1  1 = write, 0 = read.
REQ-008 cpu_addr  input  ADDR_W  CPU word address.
REQ-009 cpu_wdata  input  DATA_W  CPU write data.
REQ-010 cpu_ready  output  1  one-cycle completion pulse; drives the control unit `ready`.
REQ-011 cpu_rdata  output  DATA_W  CPU read data, valid while cpu_ready=1.
REQ-012 dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/ADDR_W/DATA_W  debug-port request, same meaning as CPU fields.
REQ-013 dbg_ack  output  1  one-cycle debug completion pulse.
REQ-014 dbg_rdata  output  DATA_W  debug read data, valid while dbg_ack=1.
REQ-015 mem_en, mem_we  output  1/1  registered single-port RAM enable/write strobe.
REQ-016 mem_addr, mem_wdata  output  ADDR_W/DATA_W  registered RAM address/write data.
REQ-017 mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0.
REQ-018 arb_busy  output  1  high in any non-IDLE state.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE_CPU, RESP_CPU, ISSUE_DBG, RESP_DBG.
REQ-020 In IDLE and in either RESP state, arbitration SHALL evaluate cpu_req/dbg_req; a winner moves to its ISSUE state at the next edge; no request moves to IDLE.
REQ-021 On grant, the winner's we/addr/wdata SHALL be latched into mem_we/mem_addr/mem_wdata and mem_en SHALL be 1 for exactly the ISSUE cycle.
REQ-022 ISSUE_x SHALL unconditionally advance to RESP_x.
REQ-023 In RESP_CPU, cpu_ready=1 and cpu_rdata=mem_rdata; in RESP_DBG, dbg_ack=1 and dbg_rdata=mem_rdata; otherwise these outputs SHALL be 0.
REQ-024 Latency: request sampled at edge N, mem_en high during cycle N+1, ready/ack high during cycle N+2; sustained throughput one access per 2 cycles.
REQ-025 Write accesses SHALL still produce the ready/ack pulse; rdata content is don't-care for writes.
REQ-026 Requester fields SHALL be ignored after the grant edge; dropping req during ISSUE SHALL NOT cancel the access or the pulse.
REQ-027 A req still high during its own RESP cycle SHALL be treated as a new request.
REQ-028 Simultaneous requests SHALL be resolved round-robin: a 1-bit priority register points to the requester not granted last; a single requester always wins.
REQ-029 mem_en SHALL never be high in two consecutive cycles.

Reset
REQ-030 While rst_n=0 at a clock edge: state IDLE, priority=CPU, all outputs 0.
REQ-031 Reset mid-access SHALL abort it: no ready/ack pulse is produced for the aborted request.

Configuration
REQ-032 Macro MEM_ARB_DBG_EN: defined, the debug port and round-robin arbitration are built; undefined, dbg_* inputs are ignored, dbg_ack/dbg_rdata are tied 0, ISSUE_DBG/RESP_DBG are absent, CPU timing is unchanged.

Verification
REQ-033 Reset, then CPU read addr 0x005 with RAM[5]=0x1234 -> mem_en at N+1 with mem_addr=0x005, cpu_ready and cpu_rdata=0x1234 at N+2.
REQ-034 CPU write 0x00A<-0xBEEF, then read 0x00A -> mem_we=1 only in first ISSUE; read returns 0xBEEF; two cpu_ready pulses 2 cycles apart under back-to-back requests.
REQ-035 cpu_req and dbg_req held high for 8 cycles after reset -> grants alternate CPU,DBG,CPU,DBG; ready/ack pulses interleave every 2 cycles.
REQ-036 rst_n low during ISSUE_CPU -> no cpu_ready pulse; all outputs 0 next cycle; a new request completes normally.
REQ-037 cpu_req pulsed 1 cycle with addr 0x3FF, then addr changed -> mem_addr=0x3FF, cpu_ready still pulses at N+2.
REQ-038 MEM_ARB_DBG_EN undefined, dbg_req=1 constantly -> dbg_ack stays 0; CPU latency remains 2 cycles.
